// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: streams loader beats into memory, then fetches from an
// internal PC and registers each instruction for the core, handling stall, branch, halt and faults.
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_WIDTH              = 32,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0,
  parameter int unsigned MEM_DEPTH_WORDS         = 256,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD     = 32'h00000073
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  loadValid,
  input  logic [DATA_WIDTH-1:0] loadData,
  output logic                  loadReady,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memWriteEnable,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic [DATA_WIDTH-1:0] memInstruction,
  input  logic                  stall,
  input  logic                  branchTaken,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instrValid,
  output logic                  halted,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] faultAddress
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StHalt, StFault} state_e;

  // One extra bit so the limit is representable even when the memory spans the address space.
  localparam logic [ADDR_WIDTH:0] MemLimit = (ADDR_WIDTH + 1)'(MEM_DEPTH_WORDS) << 2;
  localparam logic [ADDR_WIDTH-1:0] DepthWords = ADDR_WIDTH'(MEM_DEPTH_WORDS);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  halted_q, halted_d;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;

  logic                  do_start;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] wp_bytes;
  logic                  next_pc_bad;

  assign do_start    = start && (state_q != StRun);
  assign next_pc     = branchTaken ? branchTarget : fetch_pc_q + ADDR_WIDTH'(4);
  assign next_pc_bad = (next_pc[1:0] != 2'b00) || ({1'b0, next_pc} >= MemLimit);
  assign wp_bytes    = wp_q << 2;

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    wp_d           = wp_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instr_valid_d  = instr_valid_q;
    halted_d       = halted_q;
    fault_d        = fault_q;
    fault_addr_d   = fault_addr_q;
    loadReady      = ((state_q == StIdle) || (state_q == StLoad)) && !start;
    memAddress     = '0;
    memWriteEnable = 1'b0;
    memWriteData   = '0;

    if (do_start) begin
      state_d       = StRun;
      fetch_pc_d    = RESET_PC;
      wp_d          = '0;
      instr_valid_d = 1'b0;
      halted_d      = 1'b0;
      fault_d       = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StLoad: begin
          if (loadValid) begin
            if (wp_q == DepthWords) begin
              state_d      = StFault;
              fault_d      = 1'b1;
              fault_addr_d = wp_bytes;
            end else begin
              state_d        = StLoad;
              memWriteEnable = 1'b1;
              memAddress     = wp_bytes;
              memWriteData   = loadData;
              wp_d           = wp_q + ADDR_WIDTH'(1);
            end
          end
        end
        StRun: begin
          memAddress = fetch_pc_q;
          if (!stall) begin
            // Halt wins over both branch and fault: the next PC is never used.
            if (memInstruction == HALT_WORD) begin
              state_d       = StHalt;
              instr_valid_d = 1'b0;
              halted_d      = 1'b1;
            end else if (next_pc_bad) begin
              state_d       = StFault;
              fault_d       = 1'b1;
              fault_addr_d  = next_pc;
              instr_valid_d = 1'b0;
            end else begin
              instr_d       = memInstruction;
              pc_d          = fetch_pc_q;
              instr_valid_d = 1'b1;
              fetch_pc_d    = next_pc;
            end
          end
        end
        StHalt, StFault: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      wp_q          <= '0;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      wp_q          <= wp_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign pc           = pc_q;
  assign instruction  = instr_q;
  assign instrValid   = instr_valid_q;
  assign halted       = halted_q;
  assign fault        = fault_q;
  assign faultAddress = fault_addr_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a vector table for load/run/stall/branch/halt/fault,
// plus hand sequences for async reset, sequential overrun and load overflow at depth 2.
module tb_imem_fetch_ctrl;

  logic        clk, rst, start, loadValid, loadReady, memWriteEnable;
  logic [31:0] loadData, memAddress, memWriteData, memInstruction;
  logic        stall, branchTaken, instrValid, halted, fault;
  logic [31:0] branchTarget, pc, instruction, faultAddress;

  logic        start2, load_valid2, load_ready2, we2, valid2, halted2, fault2;
  logic [31:0] load_data2, addr2, wdata2, rdata2, pc2, instr2, fault_addr2;

  logic [31:0] mem [256];
  logic [31:0] mem2 [2];
  logic        mem_clr;

  int total = 0;
  int bad   = 0;

  imem_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .loadValid(loadValid), .loadData(loadData),
    .loadReady(loadReady), .memAddress(memAddress), .memWriteEnable(memWriteEnable),
    .memWriteData(memWriteData), .memInstruction(memInstruction), .stall(stall),
    .branchTaken(branchTaken), .branchTarget(branchTarget), .pc(pc),
    .instruction(instruction), .instrValid(instrValid), .halted(halted), .fault(fault),
    .faultAddress(faultAddress)
  );

  imem_fetch_ctrl #(.MEM_DEPTH_WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .loadValid(load_valid2), .loadData(load_data2),
    .loadReady(load_ready2), .memAddress(addr2), .memWriteEnable(we2),
    .memWriteData(wdata2), .memInstruction(rdata2), .stall(1'b0),
    .branchTaken(1'b0), .branchTarget(32'h0), .pc(pc2),
    .instruction(instr2), .instrValid(valid2), .halted(halted2), .fault(fault2),
    .faultAddress(fault_addr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-cycle memories: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (memWriteEnable) begin
      mem[memAddress[9:2]] <= memWriteData;
    end
    if (we2) mem2[addr2[2]] <= wdata2;
  end
  assign memInstruction = mem[memAddress[9:2]];
  assign rdata2         = mem2[addr2[2]];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic st, lv; logic [31:0] ld; logic stl, bt; logic [31:0] tgt;
    logic e_lr; logic [31:0] e_ma; logic e_we;
    logic [31:0] e_pc, e_ins; logic e_v, e_h, e_f; logic [31:0] e_fa;
  } vec_t;

  vec_t vt [24];

  function automatic vec_t mk(logic st, logic lv, logic [31:0] ld, logic stl, logic bt,
                              logic [31:0] tgt, logic lr, logic [31:0] ma, logic we,
                              logic [31:0] epc, logic [31:0] ins, logic v, logic h, logic f,
                              logic [31:0] fa);
    vec_t r;
    r.st = st; r.lv = lv; r.ld = ld; r.stl = stl; r.bt = bt; r.tgt = tgt;
    r.e_lr = lr; r.e_ma = ma; r.e_we = we;
    r.e_pc = epc; r.e_ins = ins; r.e_v = v; r.e_h = h; r.e_f = f; r.e_fa = fa;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;

    rst = 1'b1; mem_clr = 1'b1;
    start = 0; loadValid = 0; loadData = 0; stall = 0; branchTaken = 0; branchTarget = 0;
    start2 = 0; load_valid2 = 0; load_data2 = 0;

    //            st lv ld     stl bt tgt  lr ma  we  pc  ins    v  h  f  fa
    vt[0]  = mk(0, 0, 32'h0,  0, 0, 32'h0, 1, 0,  0, 0,  32'h0,  0, 0, 0, 0);
    vt[1]  = mk(0, 1, 32'h11, 0, 0, 32'h0, 1, 0,  1, 0,  32'h0,  0, 0, 0, 0);
    vt[2]  = mk(0, 1, 32'h22, 0, 0, 32'h0, 1, 4,  1, 0,  32'h0,  0, 0, 0, 0);
    vt[3]  = mk(0, 1, 32'h33, 0, 0, 32'h0, 1, 8,  1, 0,  32'h0,  0, 0, 0, 0);
    vt[4]  = mk(0, 1, 32'h44, 0, 0, 32'h0, 1, 12, 1, 0,  32'h0,  0, 0, 0, 0);
    vt[5]  = mk(0, 1, 32'h73, 0, 0, 32'h0, 1, 16, 1, 0,  32'h0,  0, 0, 0, 0);
    vt[6]  = mk(1, 1, 32'hEE, 0, 0, 32'h0, 0, 0,  0, 0,  32'h0,  0, 0, 0, 0);
    vt[7]  = mk(0, 0, 32'h0,  0, 0, 32'h0, 0, 0,  0, 0,  32'h11, 1, 0, 0, 0);
    vt[8]  = mk(0, 0, 32'h0,  0, 0, 32'h0, 0, 4,  0, 4,  32'h22, 1, 0, 0, 0);
    vt[9]  = mk(0, 0, 32'h0,  1, 1, 32'h0, 0, 8,  0, 4,  32'h22, 1, 0, 0, 0);
    vt[10] = mk(0, 0, 32'h0,  1, 1, 32'h0, 0, 8,  0, 4,  32'h22, 1, 0, 0, 0);
    vt[11] = mk(0, 0, 32'h0,  1, 0, 32'h0, 0, 8,  0, 4,  32'h22, 1, 0, 0, 0);
    vt[12] = mk(0, 0, 32'h0,  0, 1, 32'h0, 0, 8,  0, 8,  32'h33, 1, 0, 0, 0);
    vt[13] = mk(0, 0, 32'h0,  0, 0, 32'h0, 0, 0,  0, 0,  32'h11, 1, 0, 0, 0);
    vt[14] = mk(0, 0, 32'h0,  0, 0, 32'h0, 0, 4,  0, 4,  32'h22, 1, 0, 0, 0);
    vt[15] = mk(0, 0, 32'h0,  0, 0, 32'h0, 0, 8,  0, 8,  32'h33, 1, 0, 0, 0);
    vt[16] = mk(0, 0, 32'h0,  0, 0, 32'h0, 0, 12, 0, 12, 32'h44, 1, 0, 0, 0);
    vt[17] = mk(0, 0, 32'h0,  0, 0, 32'h0, 0, 16, 0, 12, 32'h44, 0, 1, 0, 0);
    vt[18] = mk(1, 0, 32'h0,  0, 0, 32'h0, 0, 0,  0, 12, 32'h44, 0, 0, 0, 0);
    vt[19] = mk(0, 0, 32'h0,  0, 0, 32'h0, 0, 0,  0, 0,  32'h11, 1, 0, 0, 0);
    vt[20] = mk(0, 0, 32'h0,  0, 1, 32'h6, 0, 4,  0, 0,  32'h11, 0, 0, 1, 6);
    vt[21] = mk(0, 0, 32'h0,  0, 0, 32'h0, 0, 0,  0, 0,  32'h11, 0, 0, 1, 6);
    vt[22] = mk(1, 0, 32'h0,  0, 0, 32'h0, 0, 0,  0, 0,  32'h11, 0, 0, 0, 6);
    vt[23] = mk(0, 0, 32'h0,  0, 0, 32'h0, 0, 0,  0, 0,  32'h11, 1, 0, 0, 6);

    tick; tick;
    rst = 1'b0; mem_clr = 1'b0;
    #1;
    chk("reset pc", pc, 32'h0);
    chk("reset instrValid", {31'h0, instrValid}, 32'h0);
    chk("reset halted", {31'h0, halted}, 32'h0);
    chk("reset fault", {31'h0, fault}, 32'h0);
    chk("reset loadReady", {31'h0, loadReady}, 32'h1);

    for (int i = 0; i < 24; i++) begin
      start = vt[i].st; loadValid = vt[i].lv; loadData = vt[i].ld;
      stall = vt[i].stl; branchTaken = vt[i].bt; branchTarget = vt[i].tgt;
      #2;
      chk($sformatf("row%0d loadReady", i), {31'h0, loadReady}, {31'h0, vt[i].e_lr});
      chk($sformatf("row%0d memAddress", i), memAddress, vt[i].e_ma);
      chk($sformatf("row%0d memWriteEnable", i), {31'h0, memWriteEnable}, {31'h0, vt[i].e_we});
      tick;
      chk($sformatf("row%0d pc", i), pc, vt[i].e_pc);
      chk($sformatf("row%0d instruction", i), instruction, vt[i].e_ins);
      chk($sformatf("row%0d instrValid", i), {31'h0, instrValid}, {31'h0, vt[i].e_v});
      chk($sformatf("row%0d halted", i), {31'h0, halted}, {31'h0, vt[i].e_h});
      chk($sformatf("row%0d fault", i), {31'h0, fault}, {31'h0, vt[i].e_f});
      chk($sformatf("row%0d faultAddress", i), faultAddress, vt[i].e_fa);
    end
    start = 0; loadValid = 0; stall = 0; branchTaken = 0; branchTarget = 0;

    // Asynchronous reset in the middle of a run clears outputs before any clock edge.
    tick;
    chk("prerst pc", pc, 32'h4);
    chk("prerst instrValid", {31'h0, instrValid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("asyncrst pc", pc, 32'h0);
    chk("asyncrst instruction", instruction, 32'h0);
    chk("asyncrst instrValid", {31'h0, instrValid}, 32'h0);
    chk("asyncrst faultAddress", faultAddress, 32'h0);
    chk("asyncrst loadReady", {31'h0, loadReady}, 32'h1);
    chk("asyncrst memAddress", memAddress, 32'h0);
    tick;
    rst = 1'b0;

    // Reload five words (overwriting the halt word), then run sequentially off the end.
    for (int k = 0; k < 5; k++) begin
      loadValid = 1'b1; loadData = 32'hA0 + k;
      tick;
    end
    loadValid = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    exp_pc = 32'h0;
    for (int k = 0; k < 300; k++) begin
      tick;
      if (fault) break;
      exp_ins = (exp_pc < 32'd20) ? (32'hA0 + (exp_pc >> 2)) : 32'h0;
      chk("seq pc", pc, exp_pc);
      chk("seq instruction", instruction, exp_ins);
      chk("seq instrValid", {31'h0, instrValid}, 32'h1);
      exp_pc = exp_pc + 32'd4;
    end
    chk("overrun fault", {31'h0, fault}, 32'h1);
    chk("overrun faultAddress", faultAddress, 32'h400);
    chk("overrun instrValid", {31'h0, instrValid}, 32'h0);
    chk("overrun last pc", exp_pc, 32'h3FC);

    // Depth-2 instance: third beat must not be written and must fault at 0x8.
    for (int k = 0; k < 3; k++) begin
      load_valid2 = 1'b1; load_data2 = 32'hB0 + k;
      #2;
      chk($sformatf("ovf beat%0d we", k), {31'h0, we2}, (k < 2) ? 32'h1 : 32'h0);
      if (k < 2) chk($sformatf("ovf beat%0d addr", k), addr2, 32'(k * 4));
      tick;
    end
    load_valid2 = 1'b0;
    #2;
    chk("ovf fault", {31'h0, fault2}, 32'h1);
    chk("ovf faultAddress", fault_addr2, 32'h8);
    chk("ovf instrValid", {31'h0, valid2}, 32'h0);
    chk("ovf loadReady", {31'h0, load_ready2}, 32'h0);
    chk("ovf mem0", mem2[0], 32'hB0);
    chk("ovf mem1", mem2[1], 32'hB1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
